// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory fetch port of the fetch unit.
//
// Signals
//   imem_addr   fetch address driven by the fetch unit (always equals pc)
//   imem_rdata  instruction word at imem_addr, returned combinationally
//               in the same cycle
//
// Modports
//   master  fetch unit side: drives imem_addr, reads imem_rdata
//   slave   memory side:     reads imem_addr, drives imem_rdata
//
// Protocol: there is no valid/ready handshake on this port. The memory
// must return the word for the current imem_addr within the same cycle;
// the fetch unit captures it on the next rising clock edge unless it is
// stalled or redirected.
interface pc_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus IF/ID pipeline register for a
// five-stage MIPS-style pipeline.
//
// Parameters
//   RESET_PC  PC value loaded on reset
//   NOP_WORD  instruction word placed in IF/ID whenever a bubble is inserted
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-low reset
//   imem              pc_fetch_unit_if.master (imem_addr out, imem_rdata in)
//   stall             load-use hold from the hazard unit
//   id_pcsrc          PCSrc for id_instr: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//   id_rs_val         forwarded rs value used by jr/jalr
//   ex_branch_type    EX branch kind: 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz
//   ex_rs_val/ex_rt_val  forwarded EX operands
//   ex_branch_target  EX branch target address
//   pc                current fetch PC
//   id_instr, id_pc_plus4, id_valid  IF/ID register contents
//   branch_taken, flush_id_ex        EX branch resolved taken (combinational)
//   perf_stall_cnt, perf_flush_cnt   performance counters
//
// Configuration
//   FETCH_PERF_CNT_EN  when defined, the two performance counters are
//                      implemented; otherwise both outputs are tied to 0.
//
// Next-state priority: reset > EX branch taken > stall > ID jump > sequential.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    pc_fetch_unit_if.master        imem,
    input  logic                   stall,
    input  logic [1:0]             id_pcsrc,
    input  logic [31:0]            id_rs_val,
    input  logic [2:0]             ex_branch_type,
    input  logic [31:0]            ex_rs_val,
    input  logic [31:0]            ex_rt_val,
    input  logic [31:0]            ex_branch_target,
    output logic [31:0]            pc,
    output logic [31:0]            id_instr,
    output logic [31:0]            id_pc_plus4,
    output logic                   id_valid,
    output logic                   branch_taken,
    output logic                   flush_id_ex,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_flush_cnt
);

    localparam logic [1:0] PCSRC_J  = 2'b10;
    localparam logic [1:0] PCSRC_JR = 2'b11;

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] pc_plus4;
    logic        taken;

    assign pc_plus4 = pc_q + 32'd4;   // wraps naturally at 2^32

    // EX-stage branch resolution, signed comparisons.
    always_comb begin
        taken = 1'b0;
        case (ex_branch_type)
            3'd1:    taken = (ex_rs_val == ex_rt_val);
            3'd2:    taken = (ex_rs_val != ex_rt_val);
            3'd3:    taken = ($signed(ex_rs_val) <= 32'sd0);
            3'd4:    taken = ($signed(ex_rs_val) >  32'sd0);
            3'd5:    taken = ($signed(ex_rs_val) <  32'sd0);
            default: taken = 1'b0;
        endcase
    end

    // Next-state for PC and IF/ID.
    always_comb begin
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        if (taken) begin
            // A taken branch squashes IF/ID even while the hazard unit stalls.
            pc_d          = ex_branch_target;
            id_instr_d    = NOP_WORD;
            id_pc_plus4_d = 32'd0;
            id_valid_d    = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (id_valid_q && (id_pcsrc == PCSRC_J)) begin
            pc_d          = {id_pc_plus4_q[31:28], id_instr_q[25:0], 2'b00};
            id_instr_d    = NOP_WORD;
            id_pc_plus4_d = 32'd0;
            id_valid_d    = 1'b0;
        end else if (id_valid_q && (id_pcsrc == PCSRC_JR)) begin
            pc_d          = id_rs_val & ~32'd3;   // force word alignment
            id_instr_d    = NOP_WORD;
            id_pc_plus4_d = 32'd0;
            id_valid_d    = 1'b0;
        end else begin
            pc_d          = pc_plus4;
            id_instr_d    = imem.imem_rdata;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= NOP_WORD;
            id_pc_plus4_q <= 32'd0;
            id_valid_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;
    logic        bubble;

    // A bubble is inserted by a taken branch or by an unstalled ID jump.
    assign bubble = taken || (!stall && id_valid_q && id_pcsrc[1]);

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (stall && !taken) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        if (bubble)          perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt_q <= 32'd0;
            perf_flush_cnt_q <= 32'd0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign id_instr       = id_instr_q;
    assign id_pc_plus4    = id_pc_plus4_q;
    assign id_valid       = id_valid_q;
    assign branch_taken   = taken;
    assign flush_id_ex    = taken;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. A reference model predicts the post-edge
// state for every driven cycle; the prediction is pushed to exp_q and
// popped/compared after the edge. Directed scenarios add fixed-value checks.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_WORD = 32'h0000_0020;
  localparam int W = 32 * 6 + 1;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  id_pcsrc;
  logic [31:0] id_rs_val;
  logic [2:0]  ex_branch_type;
  logic [31:0] ex_rs_val, ex_rt_val, ex_branch_target;
  logic [31:0] pc, id_instr, id_pc_plus4;
  logic        id_valid, branch_taken, flush_id_ex;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  logic [31:0] imem [0:255];

  pc_fetch_unit_if bus ();

  assign bus.imem_rdata = imem[bus.imem_addr[9:2]];

  pc_fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem             (bus),
    .stall            (stall),
    .id_pcsrc         (id_pcsrc),
    .id_rs_val        (id_rs_val),
    .ex_branch_type   (ex_branch_type),
    .ex_rs_val        (ex_rs_val),
    .ex_rt_val        (ex_rt_val),
    .ex_branch_target (ex_branch_target),
    .pc               (pc),
    .id_instr         (id_instr),
    .id_pc_plus4      (id_pc_plus4),
    .id_valid         (id_valid),
    .branch_taken     (branch_taken),
    .flush_id_ex      (flush_id_ex),
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_flush_cnt   (perf_flush_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_scnt, m_fcnt;
  logic        m_valid;

  function automatic logic model_taken(input logic [2:0] bt, input logic [31:0] rs,
                                       input logic [31:0] rt);
    logic neg, zero;
    neg  = rs[31];
    zero = (rs == 32'd0);
    if (bt == 3'd1) return rs == rt;
    if (bt == 3'd2) return rs != rt;
    if (bt == 3'd3) return neg || zero;
    if (bt == 3'd4) return !neg && !zero;
    if (bt == 3'd5) return neg;
    return 1'b0;
  endfunction

  // driver + scoreboard: one clock cycle with the given inputs
  task automatic step(input logic rst_n, input logic st, input logic [1:0] pcsrc,
                      input logic [31:0] rsv, input logic [2:0] bt,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] tgt);
    logic         tk;
    logic         bub;
    logic [W-1:0] exp_v, act_v;
    reset = rst_n; stall = st; id_pcsrc = pcsrc; id_rs_val = rsv;
    ex_branch_type = bt; ex_rs_val = rs; ex_rt_val = rt; ex_branch_target = tgt;
    #1;
    tk = model_taken(bt, rs, rt);
    n_checks++;
    if (branch_taken !== tk || flush_id_ex !== tk) begin
      n_fail++;
      $display("FAIL branch_flag: got taken=%b flush=%b, want %b (bt=%0d rs=%h rt=%h)",
               branch_taken, flush_id_ex, tk, bt, rs, rt);
    end
    // model update
    if (!rst_n) begin
      m_pc = RESET_PC; m_instr = NOP_WORD; m_pc4 = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      bub = 1'b0;
      if (tk) begin
        m_pc = tgt; bub = 1'b1;
      end else if (st) begin
        m_scnt = m_scnt + 1;
      end else if (m_valid && pcsrc == 2'b10) begin
        m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00}; bub = 1'b1;
      end else if (m_valid && pcsrc == 2'b11) begin
        m_pc = {rsv[31:2], 2'b00}; bub = 1'b1;
      end else begin
        m_instr = imem[m_pc[9:2]];
        m_pc    = m_pc + 32'd4;
        m_pc4   = m_pc;
        m_valid = 1'b1;
      end
      if (bub) begin
        m_instr = NOP_WORD; m_pc4 = 0; m_valid = 0; m_fcnt = m_fcnt + 1;
      end
    end
`ifdef FETCH_PERF_CNT_EN
    exp_v = {m_pc, m_pc, m_instr, m_pc4, m_valid, m_scnt, m_fcnt};
`else
    exp_v = {m_pc, m_pc, m_instr, m_pc4, m_valid, 32'd0, 32'd0};
`endif
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    act_v = {pc, bus.imem_addr, id_instr, id_pc_plus4, id_valid, perf_stall_cnt, perf_flush_cnt};
    exp_v = exp_q.pop_front();
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL state: got pc/addr/instr/pc4/valid/scnt/fcnt=%h, want %h", act_v, exp_v);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 2'b11, 32'h404, 3'd1, 32'd5, 32'd5, 32'h800);
    step(1'b0, 1'b0, 2'b10, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (pc !== 32'h100 || id_instr !== NOP_WORD || id_pc_plus4 !== 32'd0 || id_valid !== 1'b0 ||
        perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: got pc=%h instr=%h pc4=%h v=%b, want 100/%h/0/0",
               pc, id_instr, id_pc_plus4, id_valid, NOP_WORD);
    end
  endtask

  task automatic test_first_fetch();
    // id_pcsrc=10 must be ignored: IF/ID is empty after reset
    step(1'b1, 1'b0, 2'b10, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (pc !== 32'h104 || id_instr !== 32'h2008_0005 || id_pc_plus4 !== 32'h104 || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_fetch: got pc=%h instr=%h pc4=%h v=%b, want 104/20080005/104/1",
               pc, id_instr, id_pc_plus4, id_valid);
    end
  endtask

  task automatic test_jump();
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd1, 32'd0, 32'd0, 32'h4);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (id_instr !== 32'h0800_0040 || id_pc_plus4 !== 32'h8 || pc !== 32'h8) begin
      n_fail++;
      $display("FAIL jump_setup: got instr=%h pc4=%h pc=%h, want 08000040/8/8", id_instr, id_pc_plus4, pc);
    end
    step(1'b1, 1'b0, 2'b10, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (pc !== 32'h100 || id_valid !== 1'b0 || id_instr !== NOP_WORD) begin
      n_fail++;
      $display("FAIL j_redirect: got pc=%h v=%b instr=%h, want 100/0/%h", pc, id_valid, id_instr, NOP_WORD);
    end
    step(1'b1, 1'b0, 2'b10, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (pc !== 32'h104 || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL j_one_bubble: got pc=%h v=%b, want 104/1", pc, id_valid);
    end
    step(1'b1, 1'b0, 2'b11, 32'h0000_0403, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (pc !== 32'h400 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jr_redirect: got pc=%h v=%b, want 400/0", pc, id_valid);
    end
  endtask

  task automatic test_branch_stall();
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    step(1'b1, 1'b1, 2'b00, 32'h0, 3'd1, 32'd7, 32'd7, 32'h200);
    n_checks++;
    if (pc !== 32'h200 || id_valid !== 1'b0 || id_instr !== NOP_WORD) begin
      n_fail++;
      $display("FAIL beq_over_stall: got pc=%h v=%b instr=%h, want 200/0/%h", pc, id_valid, id_instr, NOP_WORD);
    end
  endtask

  task automatic test_branch_types();
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd5, 32'hFFFF_FFFF, 32'd0, 32'h300);
    n_checks++;
    if (pc !== 32'h300) begin
      n_fail++;
      $display("FAIL bltz_taken: got pc=%h, want 300", pc);
    end
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd4, 32'd0, 32'd0, 32'h500);
    n_checks++;
    if (pc !== 32'h308) begin
      n_fail++;
      $display("FAIL bgtz_zero: got pc=%h, want 308", pc);
    end
    // remaining codes and edge operands, checked by the model
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd2, 32'd3, 32'd3, 32'h600);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd3, 32'd0, 32'd0, 32'h640);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd3, 32'd1, 32'd0, 32'h680);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd4, 32'h7FFF_FFFF, 32'd0, 32'h6C0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd6, 32'd1, 32'd1, 32'h700);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd7, 32'd1, 32'd1, 32'h740);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd0, 32'd1, 32'd1, 32'h780);
  endtask

  task automatic test_stall();
    step(1'b0, 1'b0, 2'b00, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd1, 32'd1, 32'd1, 32'h3C);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b10, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (pc !== 32'h40 || id_pc_plus4 !== 32'h40 || id_instr !== imem[15] || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: got pc=%h pc4=%h instr=%h v=%b, want 40/40/%h/1",
               pc, id_pc_plus4, id_instr, id_valid, imem[15]);
    end
    n_checks++;
`ifdef FETCH_PERF_CNT_EN
    if (perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd1) begin
`else
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
`endif
      n_fail++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d", perf_stall_cnt, perf_flush_cnt);
    end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 1'b0, 2'b11, 32'h0000_0403, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (pc !== RESET_PC || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_jr: got pc=%h v=%b, want %h/0", pc, id_valid, RESET_PC);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    // stall beats an ID jump
    step(1'b1, 1'b1, 2'b10, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    // EX branch beats an ID jump
    step(1'b1, 1'b0, 2'b10, 32'h0, 3'd2, 32'd1, 32'd2, 32'h80);
    n_checks++;
    if (pc !== 32'h80 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_over_jump: got pc=%h v=%b, want 80/0", pc, id_valid);
    end
    // PC wrap at the top of the address space
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd1, 32'd0, 32'd0, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 2'b00, 32'h0, 3'd0, 32'd0, 32'd0, 32'h0);
    n_checks++;
    if (pc !== 32'd0 || id_pc_plus4 !== 32'd0 || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h pc4=%h v=%b, want 0/0/1", pc, id_pc_plus4, id_valid);
    end
  endtask

  task automatic test_random();
    logic        r_rst, r_st;
    logic [1:0]  r_src;
    logic [31:0] r_rsv, r_rs, r_rt, r_tgt;
    logic [2:0]  r_bt;
    for (int i = 0; i < 300; i++) begin
      r_rst = ($urandom_range(0, 39) != 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_src = 2'($urandom_range(0, 3));
      r_rsv = $urandom();
      r_bt  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      r_rs  = 32'($urandom_range(0, 2)) - 32'd1;
      r_rt  = 32'($urandom_range(0, 2)) - 32'd1;
      r_tgt = $urandom();
      r_tgt = {r_tgt[31:2], 2'b00};
      step(r_rst, r_st, r_src, r_rsv, r_bt, r_rs, r_rt, r_tgt);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; id_pcsrc = 2'b00; id_rs_val = 0;
    ex_branch_type = 3'd0; ex_rs_val = 0; ex_rt_val = 0; ex_branch_target = 0;
    for (int i = 0; i < 256; i++) imem[i] = $urandom();
    imem[8'h40] = 32'h2008_0005;
    imem[8'h01] = 32'h0800_0040;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_first_fetch();
    test_jump();
    test_branch_stall();
    test_branch_types();
    test_stall();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
